// File: rtl/parcel_sequencer_pkg.sv
// rtl/parcel_sequencer_pkg.sv - shared types and constants for the halfword parcel sequencer
package parcel_sequencer_pkg;

  localparam int PARCEL_W = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ALIGNED = 2'd0,
    MID     = 2'd1,
    SKIP_LO = 2'd2
  } parcel_seq_state_e;

endpackage

// File: rtl/parcel_sequencer.sv
// rtl/parcel_sequencer.sv - halfword parcel sequencer at the IF->PD boundary
// Optional perf counters: PARCEL_SEQ_PERF_EN
module parcel_sequencer
  import parcel_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic [XLEN-1:0]     i_redirect_pc,
  input  logic                i_fetch_valid,
  input  logic [31:0]         i_fetch_word,
  input  logic [XLEN-1:0]     i_fetch_pc,
  output logic                o_fetch_ready,
  output logic                o_sel_nop,
  output logic                o_sel_compressed,
  output logic                o_sel_spanning,
  output logic [PARCEL_W-1:0] o_raw_parcel,
  output logic [31:0]         o_spanning_instr,
  output logic [31:0]         o_effective_instr,
  output logic [XLEN-1:0]     o_program_counter,
  output logic [XLEN-1:0]     o_link_address,
  output logic [31:0]         o_span_count,
  output logic [31:0]         o_bubble_count
);

  parcel_seq_state_e   r_state, w_state;
  logic [PARCEL_W-1:0] r_hold_hi, w_hold_hi;
  logic [XLEN-1:0]     r_hold_pc, w_hold_pc;
  logic                r_sel_nop, w_sel_nop;
  logic                r_sel_c, w_sel_c;
  logic                r_sel_s, w_sel_s;
  logic [PARCEL_W-1:0] r_raw, w_raw;
  logic [31:0]         r_span, w_span;
  logic [31:0]         r_eff, w_eff;
  logic [XLEN-1:0]     r_pc, w_pc;
  logic [XLEN-1:0]     r_link, w_link;
  logic                w_held_rvc;
  logic                w_accept;
  logic                w_unused_redirect;

  // Only bit 1 of the redirect matters here; the fetch unit owns the full address.
  assign w_unused_redirect = ^{i_redirect_pc[XLEN-1:2], i_redirect_pc[0]};

  assign w_held_rvc    = (r_state == MID) && (r_hold_hi[1:0] != 2'b11);
  assign o_fetch_ready = !i_stall && !i_flush && !w_held_rvc;
  assign w_accept      = i_fetch_valid && o_fetch_ready;

  always_comb begin
    w_state   = r_state;
    w_hold_hi = r_hold_hi;
    w_hold_pc = r_hold_pc;
    w_sel_nop = 1'b1;
    w_sel_c   = 1'b0;
    w_sel_s   = 1'b0;
    w_raw     = r_raw;
    w_span    = r_span;
    w_eff     = NOP;
    w_pc      = r_pc;
    w_link    = r_link;
    if (i_flush) begin
      w_state = i_redirect_pc[1] ? SKIP_LO : ALIGNED;
    end else begin
      case (r_state)
        ALIGNED: if (w_accept) begin
          w_sel_nop = 1'b0;
          w_pc      = i_fetch_pc;
          if (i_fetch_word[1:0] == 2'b11) begin
            w_eff  = i_fetch_word;
            w_link = i_fetch_pc + XLEN'(4);
          end else begin
            w_sel_c   = 1'b1;
            w_raw     = i_fetch_word[15:0];
            w_eff     = {16'h0000, i_fetch_word[15:0]};
            w_link    = i_fetch_pc + XLEN'(2);
            w_hold_hi = i_fetch_word[31:16];
            w_hold_pc = i_fetch_pc + XLEN'(2);
            w_state   = MID;
          end
        end
        MID: if (w_held_rvc) begin
          w_sel_nop = 1'b0;
          w_sel_c   = 1'b1;
          w_raw     = r_hold_hi;
          w_eff     = {16'h0000, r_hold_hi};
          w_pc      = r_hold_pc;
          w_link    = r_hold_pc + XLEN'(2);
          w_state   = ALIGNED;
        end else if (w_accept) begin
          // Upper half of this word becomes the start of the next parcel.
          w_sel_nop = 1'b0;
          w_sel_s   = 1'b1;
          w_span    = {i_fetch_word[15:0], r_hold_hi};
          w_eff     = {i_fetch_word[15:0], r_hold_hi};
          w_pc      = r_hold_pc;
          w_link    = r_hold_pc + XLEN'(4);
          w_hold_hi = i_fetch_word[31:16];
          w_hold_pc = i_fetch_pc + XLEN'(2);
        end
        SKIP_LO: if (w_accept) begin
          w_hold_hi = i_fetch_word[31:16];
          w_hold_pc = i_fetch_pc + XLEN'(2);
          w_state   = MID;
        end
        default: w_state = ALIGNED;
      endcase
    end
  end

`ifdef PARCEL_SEQ_PERF_EN
  logic [31:0] r_span_count, r_bubble_count;
  assign o_span_count   = r_span_count;
  assign o_bubble_count = r_bubble_count;
`else
  assign o_span_count   = 32'h0;
  assign o_bubble_count = 32'h0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ALIGNED;
      r_hold_hi <= '0;
      r_hold_pc <= '0;
      r_sel_nop <= 1'b1;
      r_sel_c   <= 1'b0;
      r_sel_s   <= 1'b0;
      r_raw     <= '0;
      r_span    <= '0;
      r_eff     <= '0;
      r_pc      <= '0;
      r_link    <= '0;
`ifdef PARCEL_SEQ_PERF_EN
      r_span_count   <= '0;
      r_bubble_count <= '0;
`endif
    end else if (i_flush || !i_stall) begin
      r_state   <= w_state;
      r_hold_hi <= w_hold_hi;
      r_hold_pc <= w_hold_pc;
      r_sel_nop <= w_sel_nop;
      r_sel_c   <= w_sel_c;
      r_sel_s   <= w_sel_s;
      r_raw     <= w_raw;
      r_span    <= w_span;
      r_eff     <= w_eff;
      r_pc      <= w_pc;
      r_link    <= w_link;
`ifdef PARCEL_SEQ_PERF_EN
      if (w_sel_s && (r_span_count != 32'hFFFF_FFFF)) r_span_count <= r_span_count + 32'd1;
      if (w_sel_nop && (r_bubble_count != 32'hFFFF_FFFF)) r_bubble_count <= r_bubble_count + 32'd1;
`endif
    end
  end

  assign o_sel_nop         = r_sel_nop;
  assign o_sel_compressed  = r_sel_c;
  assign o_sel_spanning    = r_sel_s;
  assign o_raw_parcel      = r_raw;
  assign o_spanning_instr  = r_span;
  assign o_effective_instr = r_eff;
  assign o_program_counter = r_pc;
  assign o_link_address    = r_link;

endmodule

// File: tb/tb_parcel_sequencer.sv
// tb/tb_parcel_sequencer.sv - self-checking bench for parcel_sequencer against a halfword-stream model
module tb_parcel_sequencer;

  localparam int XLEN = 32;

  logic            i_clk = 1'b0;
  logic            i_rst, i_stall, i_flush, i_fetch_valid;
  logic [XLEN-1:0] i_redirect_pc, i_fetch_pc;
  logic [31:0]     i_fetch_word;
  logic            o_fetch_ready, o_sel_nop, o_sel_compressed, o_sel_spanning;
  logic [15:0]     o_raw_parcel;
  logic [31:0]     o_spanning_instr, o_effective_instr, o_span_count, o_bubble_count;
  logic [XLEN-1:0] o_program_counter, o_link_address;

  parcel_sequencer #(.XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
    .i_redirect_pc(i_redirect_pc), .i_fetch_valid(i_fetch_valid),
    .i_fetch_word(i_fetch_word), .i_fetch_pc(i_fetch_pc), .o_fetch_ready(o_fetch_ready),
    .o_sel_nop(o_sel_nop), .o_sel_compressed(o_sel_compressed), .o_sel_spanning(o_sel_spanning),
    .o_raw_parcel(o_raw_parcel), .o_spanning_instr(o_spanning_instr),
    .o_effective_instr(o_effective_instr), .o_program_counter(o_program_counter),
    .o_link_address(o_link_address), .o_span_count(o_span_count), .o_bubble_count(o_bubble_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rst, stall, flush, valid;
    logic [31:0] word, pc, redir;
  } stim_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: at most one buffered halfword plus a "drop next low half" flag.
  logic        m_hv, m_skip;
  logic [15:0] m_hd;
  logic [31:0] m_hpc;
  logic        e_nop, e_c, e_s, e_ready, obs_ready;
  logic [31:0] e_pc, e_link, e_eff, e_span, e_spans, e_bubbles;
  logic [15:0] e_raw;

  function automatic stim_t mk(input logic rst, stall, flush, valid,
                               input logic [31:0] word, pc, redir);
    stim_t s;
    s.rst = rst; s.stall = stall; s.flush = flush; s.valid = valid;
    s.word = word; s.pc = pc; s.redir = redir;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    i_rst = s.rst; i_stall = s.stall; i_flush = s.flush; i_fetch_valid = s.valid;
    i_fetch_word = s.word; i_fetch_pc = s.pc; i_redirect_pc = s.redir;
  endtask

  function automatic logic [146:0] obs_bundle();
    return {o_sel_nop, o_sel_compressed, o_sel_spanning,
            o_sel_nop ? 32'h0 : o_program_counter, o_sel_nop ? 32'h0 : o_link_address,
            (o_sel_nop | o_sel_compressed) ? 32'h0 : o_effective_instr,
            o_sel_compressed ? o_raw_parcel : 16'h0, o_sel_spanning ? o_spanning_instr : 32'h0};
  endfunction

  function automatic logic [146:0] exp_bundle();
    return {e_nop, e_c, e_s, e_pc, e_link, e_eff, e_raw, e_span};
  endfunction

  task automatic issue_nop();
    e_nop = 1; e_c = 0; e_s = 0; e_pc = 0; e_link = 0; e_eff = 0; e_raw = 0; e_span = 0;
`ifdef PARCEL_SEQ_PERF_EN
    if (e_bubbles != 32'hFFFF_FFFF) e_bubbles = e_bubbles + 1;
`endif
  endtask

  task automatic issue16(input logic [15:0] p, input logic [31:0] pc);
    e_nop = 0; e_c = 1; e_s = 0; e_pc = pc; e_link = pc + 2; e_eff = 0; e_raw = p; e_span = 0;
  endtask

  // A 32-bit instruction starting on an odd halfword is by definition a spanning issue.
  task automatic issue32(input logic [31:0] instr, input logic [31:0] pc);
    e_nop = 0; e_c = 0; e_s = pc[1]; e_pc = pc; e_link = pc + 4; e_eff = instr; e_raw = 0;
    e_span = pc[1] ? instr : 32'h0;
`ifdef PARCEL_SEQ_PERF_EN
    if (pc[1] && e_spans != 32'hFFFF_FFFF) e_spans = e_spans + 1;
`endif
  endtask

  task automatic model_step();
    logic accept;
    logic [15:0] lo, hi;
    lo = i_fetch_word[15:0];
    hi = i_fetch_word[31:16];
    e_ready = !i_stall && !i_flush && !(m_hv && m_hd[1:0] != 2'b11);
    accept = i_fetch_valid && e_ready;
    if (i_rst) begin
      m_hv = 0; m_skip = 0; m_hd = 0; m_hpc = 0;
      e_nop = 1; e_c = 0; e_s = 0; e_pc = 0; e_link = 0; e_eff = 0; e_raw = 0; e_span = 0;
      e_spans = 0; e_bubbles = 0;
    end else if (i_flush) begin
      m_hv = 0; m_skip = i_redirect_pc[1];
      issue_nop();
    end else if (!i_stall) begin
      if (m_hv && m_hd[1:0] != 2'b11) begin
        issue16(m_hd, m_hpc); m_hv = 0;
      end else if (!accept) begin
        issue_nop();
      end else if (m_skip) begin
        m_skip = 0; m_hv = 1; m_hd = hi; m_hpc = i_fetch_pc + 2; issue_nop();
      end else if (m_hv) begin
        issue32({lo, m_hd}, m_hpc); m_hd = hi; m_hpc = i_fetch_pc + 2;
      end else if (lo[1:0] == 2'b11) begin
        issue32(i_fetch_word, i_fetch_pc);
      end else begin
        issue16(lo, i_fetch_pc); m_hv = 1; m_hd = hi; m_hpc = i_fetch_pc + 2;
      end
    end
  endtask

  task automatic tick();
    #1;
    obs_ready = o_fetch_ready;
    model_step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    drive(mk(1, 0, 0, 0, 0, 0, 0));
    tick(); tick();
    n_cmp++;
    if ({o_sel_nop, o_sel_compressed, o_sel_spanning, o_raw_parcel, o_spanning_instr,
         o_effective_instr, o_program_counter, o_link_address, o_span_count, o_bubble_count}
        !== {3'b100, 208'b0}) begin
      n_bad++;
      $display("FAIL reset_state got sel=%b%b%b pc=%h eff=%h cnt=%h/%h want sel=100 all zero",
               o_sel_nop, o_sel_compressed, o_sel_spanning, o_program_counter,
               o_effective_instr, o_span_count, o_bubble_count);
    end
  endtask

  task automatic test_aligned();
    stim_t s[$];
    logic [31:0] x_pc[2], x_link[2], x_eff[2];
    logic saw_c;
    x_pc = '{32'h0, 32'h4}; x_link = '{32'h4, 32'h8}; x_eff = '{32'h13, 32'h0010_0093};
    s.push_back(mk(0, 0, 0, 1, 32'h0000_0013, 32'h0, 0));
    s.push_back(mk(0, 0, 0, 1, 32'h0010_0093, 32'h4, 0));
    saw_c = 0;
    foreach (s[i]) begin
      drive(s[i]); tick();
      saw_c |= o_sel_compressed;
      n_cmp++;
      if (obs_bundle() !== exp_bundle()) begin
        n_bad++; $display("FAIL aligned[%0d] bundle got=%h want=%h", i, obs_bundle(), exp_bundle());
      end
      n_cmp++;
      if ({o_sel_nop, o_program_counter, o_link_address, o_effective_instr}
          !== {1'b0, x_pc[i], x_link[i], x_eff[i]}) begin
        n_bad++; $display("FAIL aligned_issue[%0d] got pc=%h link=%h eff=%h want pc=%h link=%h eff=%h",
                          i, o_program_counter, o_link_address, o_effective_instr, x_pc[i], x_link[i], x_eff[i]);
      end
    end
    n_cmp++;
    if (saw_c !== 1'b0) begin
      n_bad++; $display("FAIL aligned_no_rvc got sel_compressed=1 want 0");
    end
  endtask

  task automatic test_compressed();
    stim_t s[$];
    logic [31:0] x_pc[2];
    x_pc = '{32'h100, 32'h102};
    s.push_back(mk(0, 0, 0, 1, 32'h4501_4501, 32'h100, 0));
    s.push_back(mk(0, 0, 0, 1, 32'h0000_0013, 32'h104, 0));
    foreach (s[i]) begin
      drive(s[i]); tick();
      n_cmp++;
      if (obs_bundle() !== exp_bundle() || obs_ready !== e_ready) begin
        n_bad++; $display("FAIL rvc[%0d] got=%h rdy=%b want=%h rdy=%b", i, obs_bundle(), obs_ready, exp_bundle(), e_ready);
      end
      n_cmp++;
      if ({o_sel_compressed, o_raw_parcel, o_program_counter, o_link_address}
          !== {1'b1, 16'h4501, x_pc[i], x_pc[i] + 32'd2} || (i == 1 && obs_ready !== 1'b0)) begin
        n_bad++; $display("FAIL rvc_issue[%0d] got c=%b raw=%h pc=%h link=%h rdy=%b", i, o_sel_compressed,
                          o_raw_parcel, o_program_counter, o_link_address, obs_ready);
      end
    end
  endtask

  task automatic test_span_flush();
    stim_t s[$];
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 32'h0093_4501, 32'h200, 0));
    s.push_back(mk(0, 0, 0, 1, 32'h0000_0000, 32'h204, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 32'h208, 0));
    s.push_back(mk(0, 0, 1, 1, 32'h1111_1111, 32'h208, 32'h302));
    s.push_back(mk(0, 0, 0, 1, 32'h4505_FFFF, 32'h300, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 32'h304, 0));
    foreach (s[i]) begin
      drive(s[i]); tick();
      n_cmp++;
      if (obs_bundle() !== exp_bundle() || obs_ready !== e_ready) begin
        n_bad++; $display("FAIL span_flush[%0d] got=%h rdy=%b want=%h rdy=%b", i, obs_bundle(), obs_ready, exp_bundle(), e_ready);
      end
      if (i == 2) begin
        n_cmp++;
        if ({o_sel_spanning, o_spanning_instr, o_program_counter, o_link_address, obs_ready}
            !== {1'b1, 32'h0000_0093, 32'h202, 32'h206, 1'b1}) begin
          n_bad++; $display("FAIL span_issue got s=%b instr=%h pc=%h link=%h want 1 00000093 202 206",
                            o_sel_spanning, o_spanning_instr, o_program_counter, o_link_address);
        end
      end
      if (i == 4 || i == 5) begin
        n_cmp++;
        if (o_sel_nop !== 1'b1) begin
          n_bad++; $display("FAIL flush_nop[%0d] got sel_nop=%b want 1", i, o_sel_nop);
        end
      end
      if (i == 6) begin
        n_cmp++;
        if ({o_sel_compressed, o_raw_parcel, o_program_counter} !== {1'b1, 16'h4505, 32'h302}) begin
          n_bad++; $display("FAIL redirect_issue got c=%b raw=%h pc=%h want 1 4505 302",
                            o_sel_compressed, o_raw_parcel, o_program_counter);
        end
      end
    end
    n_cmp++;
`ifdef PARCEL_SEQ_PERF_EN
    if ({o_span_count, o_bubble_count} !== {32'd1, 32'd2}) begin
`else
    if ({o_span_count, o_bubble_count} !== 64'd0) begin
`endif
      n_bad++; $display("FAIL perf_counts got span=%0d bubble=%0d", o_span_count, o_bubble_count);
    end
    drive(mk(1, 0, 0, 0, 0, 0, 0)); tick();
    n_cmp++;
    if ({o_span_count, o_bubble_count} !== 64'd0) begin
      n_bad++; $display("FAIL perf_reset got span=%0d bubble=%0d want 0/0", o_span_count, o_bubble_count);
    end
  endtask

  task automatic test_stall();
    stim_t s[$];
    logic [146:0] snap;
    logic [63:0]  snap_cnt;
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 32'h0093_4501, 32'h200, 0));
    for (int k = 0; k < 3; k++) s.push_back(mk(0, 1, 0, 1, 32'h0, 32'h204, 0));
    s.push_back(mk(0, 0, 0, 1, 32'h0, 32'h204, 0));
    snap = '0; snap_cnt = '0;
    foreach (s[i]) begin
      drive(s[i]); tick();
      n_cmp++;
      if (obs_bundle() !== exp_bundle() || obs_ready !== e_ready) begin
        n_bad++; $display("FAIL stall[%0d] got=%h rdy=%b want=%h rdy=%b", i, obs_bundle(), obs_ready, exp_bundle(), e_ready);
      end
      if (i == 1) begin
        snap = obs_bundle(); snap_cnt = {o_span_count, o_bubble_count};
      end
      if (i >= 2 && i <= 4) begin
        n_cmp++;
        if (obs_bundle() !== snap || {o_span_count, o_bubble_count} !== snap_cnt || obs_ready !== 1'b0) begin
          n_bad++; $display("FAIL stall_frozen[%0d] got=%h rdy=%b want=%h rdy=0", i, obs_bundle(), obs_ready, snap);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if ({o_sel_spanning, o_spanning_instr, o_program_counter} !== {1'b1, 32'h0000_0093, 32'h202}) begin
          n_bad++; $display("FAIL stall_resume got s=%b instr=%h pc=%h want 1 00000093 202",
                            o_sel_spanning, o_spanning_instr, o_program_counter);
        end
      end
    end
  endtask

  task automatic test_random();
    stim_t st;
    logic [31:0] fpc, w;
    logic acc;
    fpc = 0;
    for (int i = 0; i < 3000; i++) begin
      w = $urandom;
      if ($urandom_range(1, 0) == 1) w[1:0] = 2'b11;
      if ($urandom_range(1, 0) == 1) w[17:16] = 2'b11;
      st = mk($urandom_range(99, 0) == 0, $urandom_range(9, 0) == 0, $urandom_range(19, 0) == 0,
              $urandom_range(3, 0) != 0, w, fpc, {$urandom, 1'b0} >> 0);
      st.redir[0] = 1'b0;
      if (i < 2) st.rst = 1'b1;
      drive(st); tick();
      acc = !st.rst && st.valid && e_ready;
      n_cmp++;
      if (obs_bundle() !== exp_bundle() || obs_ready !== e_ready ||
          {o_span_count, o_bubble_count} !== {e_spans, e_bubbles}) begin
        n_bad++; $display("FAIL random[%0d] got=%h rdy=%b cnt=%h/%h want=%h rdy=%b cnt=%h/%h", i, obs_bundle(),
                          obs_ready, o_span_count, o_bubble_count, exp_bundle(), e_ready, e_spans, e_bubbles);
      end
      if (st.rst) fpc = 0;
      else if (st.flush) fpc = st.redir & 32'hFFFF_FFFC;
      else if (acc) fpc = fpc + 4;
    end
  endtask

  initial begin
    drive(mk(1, 0, 0, 0, 0, 0, 0));
    test_reset();
    test_aligned();
    test_compressed();
    test_span_flush();
    test_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
